// File: rtl/vdiv_lane_sequencer_if.sv
// Handshake bundle between vector dispatch, the sequencer, the shared divider and the consumer.
interface vdiv_lane_sequencer_if #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned EXP_WIDTH  = 5,
  parameter int unsigned MANT_WIDTH = 10
);
  localparam int unsigned W = 1 + EXP_WIDTH + MANT_WIDTH;

  logic                   vec_valid;
  logic                   vec_ready;
  logic [NUM_LANES*W-1:0] vec_a;
  logic [NUM_LANES*W-1:0] vec_b;
  logic [NUM_LANES-1:0]   vec_mask;

  logic                   div_valid_in;
  logic                   div_ready_in;
  logic [W-1:0]           div_operand1;
  logic [W-1:0]           div_operand2;
  logic                   div_valid_out;
  logic                   div_ready_out;
  logic [W-1:0]           div_result;

  logic                   res_valid;
  logic                   res_ready;
  logic [NUM_LANES*W-1:0] res_vec;
  logic                   busy;

  // Sequencer side.
  modport master (
    input  vec_valid, vec_a, vec_b, vec_mask,
    input  div_ready_in, div_valid_out, div_result,
    input  res_ready,
    output vec_ready,
    output div_valid_in, div_operand1, div_operand2, div_ready_out,
    output res_valid, res_vec, busy
  );

  // Environment side: dispatch, divider and result consumer.
  modport slave (
    output vec_valid, vec_a, vec_b, vec_mask,
    output div_ready_in, div_valid_out, div_result,
    output res_ready,
    input  vec_ready,
    input  div_valid_in, div_operand1, div_operand2, div_ready_out,
    input  res_valid, res_vec, busy
  );
endinterface

// File: rtl/vdiv_lane_sequencer.sv
// Issues the active lanes of one vector divide op, one at a time, to a shared scalar divider
// and gathers the quotients into a result vector.
module vdiv_lane_sequencer #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned EXP_WIDTH  = 5,
  parameter int unsigned MANT_WIDTH = 10
) (
  input logic                 CLK,
  input logic                 nRST,
  vdiv_lane_sequencer_if.master bus
);
  localparam int unsigned W  = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                 state_q, state_d;
  logic [LW-1:0]          lane_q, lane_d;
  logic [NUM_LANES*W-1:0] a_q, a_d;
  logic [NUM_LANES*W-1:0] b_q, b_d;
  logic [NUM_LANES-1:0]   mask_q, mask_d;
  logic [NUM_LANES*W-1:0] res_q, res_d;

  logic          first_any, next_any;
  logic [LW-1:0] first_idx, next_idx;

  // Lowest active lane of the incoming op, and lowest active lane above the current one.
  always_comb begin
    first_any = 1'b0;
    first_idx = '0;
    next_any  = 1'b0;
    next_idx  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (bus.vec_mask[i]) begin
        first_any = 1'b1;
        first_idx = LW'(i);
      end
      if (mask_q[i] && (i > int'(lane_q))) begin
        next_any = 1'b1;
        next_idx = LW'(i);
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (bus.vec_valid) begin
          a_d    = bus.vec_a;
          b_d    = bus.vec_b;
          mask_d = bus.vec_mask;
          // Inactive lanes pass the dividend through untouched.
          res_d  = bus.vec_a;
          if (first_any) begin
            lane_d  = first_idx;
            state_d = StIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StIssue: begin
        if (bus.div_ready_in) state_d = StWait;
      end
      StWait: begin
        if (bus.div_valid_out) begin
          res_d[lane_q*W +: W] = bus.div_result;
          if (next_any) begin
            lane_d  = next_idx;
            state_d = StIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and operand registers; reset discards any op in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      lane_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      res_q   <= res_d;
    end
  end

  assign bus.vec_ready     = (state_q == StIdle);
  assign bus.div_valid_in  = (state_q == StIssue);
  assign bus.div_ready_out = (state_q == StWait);
  assign bus.res_valid     = (state_q == StDone);
  assign bus.busy          = (state_q != StIdle);
  assign bus.div_operand1  = a_q[lane_q*W +: W];
  assign bus.div_operand2  = b_q[lane_q*W +: W];
  assign bus.res_vec       = res_q;
endmodule

// File: tb/tb_vdiv_lane_sequencer.sv
// Directed bench: a small FP16 divider model answers the sequencer from a table of known quotients.
module tb_vdiv_lane_sequencer;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   cyc;
  int   hs0;
  logic ready_en = 1'b1;
  logic [15:0] op1_hold;
  logic [63:0] res_hold;

  logic        dpend;
  logic [4:0]  dcnt;
  logic [15:0] dres;

  vdiv_lane_sequencer_if #(.NUM_LANES(4), .EXP_WIDTH(5), .MANT_WIDTH(10)) bus ();

  vdiv_lane_sequencer #(.NUM_LANES(4), .EXP_WIDTH(5), .MANT_WIDTH(10)) u_dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] quot(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h4000_3C00: quot = 16'h4000;
      32'h3C00_4000: quot = 16'h3800;
      32'h4200_4000: quot = 16'h3E00;
      32'hC000_4000: quot = 16'hBC00;
      32'h3C00_0000: quot = 16'h7C00;
      32'h0000_0000: quot = 16'h7E00;
      32'h7C00_3C00: quot = 16'h7C00;
      32'h4400_4000: quot = 16'h4000;
      32'h1111_3C00: quot = 16'h1111;
      32'h4000_4000: quot = 16'h3C00;
      default:       quot = 16'hDEAD;
    endcase
  endfunction

  // Zero, Inf and NaN operands take the one-cycle fast path.
  function automatic logic [4:0] lat(input logic [15:0] a, input logic [15:0] b);
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0 || a[14:10] == 5'h1F || b[14:10] == 5'h1F)
      lat = 5'd1;
    else
      lat = 5'd12;
  endfunction

  // Divider model: ready one cycle after reset, one op at a time.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.div_ready_in  <= 1'b0;
      bus.div_valid_out <= 1'b0;
      bus.div_result    <= '0;
      dpend             <= 1'b0;
      dcnt              <= '0;
      dres              <= '0;
    end else begin
      bus.div_ready_in <= ready_en;
      if (bus.div_valid_out && bus.div_ready_out) bus.div_valid_out <= 1'b0;
      if (bus.div_valid_in && bus.div_ready_in) begin
        dpend <= 1'b1;
        dcnt  <= lat(bus.div_operand1, bus.div_operand2) - 5'd1;
        dres  <= quot(bus.div_operand1, bus.div_operand2);
      end
      if (dpend) begin
        if (dcnt == 5'd0) begin
          bus.div_valid_out <= 1'b1;
          bus.div_result    <= dres;
          dpend             <= 1'b0;
        end else begin
          dcnt <= dcnt - 5'd1;
        end
      end
    end
  end

  // Handshake counter survives reset so it spans the whole run.
  always @(posedge clk) begin
    if (bus.div_valid_in && bus.div_ready_in) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m);
    @(negedge clk);
    bus.vec_a     = a;
    bus.vec_b     = b;
    bus.vec_mask  = m;
    bus.vec_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.vec_valid = 1'b0;
    // Scramble inputs after accept; the op must not notice.
    bus.vec_a    = {$urandom, $urandom};
    bus.vec_b    = {$urandom, $urandom};
    bus.vec_mask = 4'($urandom);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.res_valid && cycles < 500) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("res_valid_drop", 64'(bus.res_valid), 64'd0);
    chk("vec_ready_back", 64'(bus.vec_ready), 64'd1);
  endtask

  initial begin
    bus.vec_valid = 1'b0;
    bus.vec_a     = '0;
    bus.vec_b     = '0;
    bus.vec_mask  = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec_ready", 64'(bus.vec_ready), 64'd1);
    chk("rst_div_valid_in", 64'(bus.div_valid_in), 64'd0);
    chk("rst_div_ready_out", 64'(bus.div_ready_out), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_res_vec", bus.res_vec, 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(posedge clk);

    // 1: four normal lanes.
    hs0 = hs_cnt;
    start_op(64'h4000_3C00_4200_C000, 64'h3C00_4000_4000_4000, 4'hF);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    wait_done(cyc);
    chk("t1_res_vec", bus.res_vec, 64'h4000_3800_3E00_BC00);
    chk("t1_cycles", 64'(cyc), 64'd56);
    chk("t1_handshakes", 64'(hs_cnt - hs0), 64'd4);
    consume();

    // 2: fast-path specials plus one normal lane; then hold res_ready low in DONE.
    hs0 = hs_cnt;
    start_op(64'h4400_7C00_0000_3C00, 64'h4000_3C00_0000_0000, 4'hF);
    wait_done(cyc);
    chk("t2_res_vec", bus.res_vec, 64'h4000_7C00_7E00_7C00);
    chk("t2_cycles", 64'(cyc), 64'd23);
    chk("t2_handshakes", 64'(hs_cnt - hs0), 64'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t5_res_valid_hold", 64'(bus.res_valid), 64'd1);
      chk("t5_res_vec_hold", bus.res_vec, 64'h4000_7C00_7E00_7C00);
      chk("t5_vec_ready_low", 64'(bus.vec_ready), 64'd0);
    end
    consume();

    // 3: sparse mask, divider stalls first; inactive lanes pass through.
    ready_en = 1'b0;
    repeat (2) @(posedge clk);
    hs0 = hs_cnt;
    start_op(64'h4400_4000_2222_1111, 64'h0000_4000_0000_3C00, 4'b0101);
    op1_hold = bus.div_operand1;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_valid_held", 64'(bus.div_valid_in), 64'd1);
    chk("t3_operand1_stable", 64'(bus.div_operand1), 64'(op1_hold));
    chk("t3_operand1_lane0", 64'(bus.div_operand1), 64'h1111);
    chk("t3_no_handshake", 64'(hs_cnt - hs0), 64'd0);
    ready_en = 1'b1;
    wait_done(cyc);
    chk("t3_res_vec", bus.res_vec, 64'h4400_3C00_2222_1111);
    chk("t3_handshakes", 64'(hs_cnt - hs0), 64'd2);
    consume();

    // 4: empty mask completes without touching the divider.
    hs0 = hs_cnt;
    start_op(64'h1234_5678_9ABC_DEF0, 64'h3C00_3C00_3C00_3C00, 4'h0);
    chk("t4_res_valid_next", 64'(bus.res_valid), 64'd1);
    chk("t4_div_valid_in", 64'(bus.div_valid_in), 64'd0);
    wait_done(cyc);
    chk("t4_cycles", 64'(cyc), 64'd0);
    chk("t4_res_vec", bus.res_vec, 64'h1234_5678_9ABC_DEF0);
    chk("t4_handshakes", 64'(hs_cnt - hs0), 64'd0);
    consume();

    // 6: asynchronous reset while waiting on the divider, then a fresh op.
    start_op(64'h4000_3C00_4200_C000, 64'h3C00_4000_4000_4000, 4'hF);
    cyc = 0;
    while (!bus.div_ready_out && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("t6_reach_wait", 64'(bus.div_ready_out), 64'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("t6_vec_ready", 64'(bus.vec_ready), 64'd1);
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_div_ready_out", 64'(bus.div_ready_out), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    hs0 = hs_cnt;
    start_op(64'h4000_3C00_4200_C000, 64'h3C00_4000_4000_4000, 4'hF);
    wait_done(cyc);
    chk("t6_res_vec", bus.res_vec, 64'h4000_3800_3E00_BC00);
    chk("t6_cycles", 64'(cyc), 64'd56);
    chk("t6_handshakes", 64'(hs_cnt - hs0), 64'd4);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
